rvfi_dmem_multi_check: RTL and testbench
========================================

# rvfi_dmem_multi_check

Formal and simulation checker for data-memory consistency across several tracked word addresses and multiple retire channels. It watches the RVFI retire bus and keeps a byte-granular shadow of the last write to each tracked address. Every later read of a byte already written must return the shadowed value. It sits beside the core in the riscv_formal harness. Mismatches are reported as registered, sticky error outputs plus first-failure capture, with an optional immediate assertion.

## Interface
- `XLEN`, 32: data/address width; multiple of 8.
- `NRET`, 1: retire channels on the RVFI bus.
- `NADDR`, 2: tracked word addresses (slots).
- `CNT_W`, 8: width of the saturating error counter.
- `ASSERT_EN`, 1: when 1, each mismatch also fires an immediate `assert`.

- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low; asserted while 0.
- `enable`  in  1  check enable; shadow updates regardless.
- `trk_addr`  in  NADDR*XLEN  tracked addresses, slot k at `[k*XLEN +: XLEN]`; held constant by the harness.
- `rvfi_valid`, `rvfi_mem_addr`, `rvfi_mem_rmask`, `rvfi_mem_wmask`, `rvfi_mem_rdata`, `rvfi_mem_wdata`  in  standard RVFI widths × NRET  retire bus.
- `err`  out  1  sticky mismatch flag.
- `err_count`  out  CNT_W  mismatched bytes, saturating.
- `err_chan`  out  clog2(NRET)+1  channel of first failure.
- `err_slot`  out  clog2(NADDR)+1  slot of first failure.
- `err_byte`  out  clog2(XLEN/8)+1  byte lane of first failure.
- `err_exp`, `err_act`  out  8 each  shadow and observed bytes of first failure.

## Operation
- **Matching.** Channel c matches slot k when `rvfi_valid[c]`, `rvfi_mem_addr` slice c equals `trk_addr` slot k, and the address is XLEN/8-aligned.
  - Misaligned retires are ignored for checking and updating.
  - Data is taken from channel c's own slice of rdata/wdata, never lane 0.
- **Per-slot state.** `shadow[XLEN]` and `written[XLEN/8]`.
  - A byte with wmask set stores the wdata byte and sets `written`.
- **Check.** Byte i of slot k mismatches when all of the following hold: `enable`, rmask[i], written[i] (effective), and rdata byte ≠ effective shadow byte.
- **Intra-cycle ordering.** Channels are processed in ascending index.
  - The effective shadow/written for channel c includes writes from channels < c in the same cycle.
  - The same channel's read is checked before its own write is applied.
- **Duplicate `trk_addr` values.** Each slot tracks independently, so one bad byte counts once per duplicate slot.
- **First failure.** Captured only while `err`=0. Priority within a cycle: lowest channel, then lowest slot, then lowest byte.
- **Error counter.** `err_count` adds the number of mismatching bytes in the cycle and saturates at all-ones.

## Timing
- **Reset** (async, `reset`=0): all outputs 0, all `written` 0. Shadow contents are don't-care.
- **Latency.** Mismatch on retire cycle N leads to `err`/capture/count updated at edge ending N, visible in N+1.
  - `ASSERT_EN` assert fires combinationally in cycle N.
- **Shadow writes** in cycle N become visible to other cycles from N+1. Later channels see them in cycle N through forwarding.
- **Reset mid-stream** clears `written`. Reads before the next write are not checked.
- **`enable`=0:** no mismatches, counter frozen; writes still recorded.

## Structure
- Package `rvfi_check_pkg`:
  - `err_info_t` struct (chan, slot, byte, exp, act)
  - `CNT_W` default
  - `clog2`-based index width helpers
- Sub-module `rvfi_dmem_slot`, one per tracked address: holds shadow/written, performs the channel-ordered forwarding chain, emits per-channel, per-byte mismatch vectors.
- Top level: priority-encodes mismatches into first-failure capture and popcounts them into `err_count`.

## Test plan
- XLEN=32, NRET=1: write 0xDEADBEEF wmask 0xF to slot 0, then read same address rdata 0xDEADBEEF rmask 0xF → `err`=0, `err_count`=0.
- Same setup, then read rdata 0xDEADBE00 → `err`=1 next cycle; `err_byte`=0, `err_exp`=0xEF, `err_act`=0x00, `err_count`=1.
- NRET=2, same cycle: ch0 writes 0x11223344, ch1 reads 0x11223344 → no error. Repeat with ch1 rdata 0x11223345 → `err_chan`=1, `err_byte`=0.
- Read with no prior write, then `reset` pulsed low between a write and a mismatching read → no error in both cases; misaligned address `trk_addr`+1 read/write → ignored.
- `enable`=0 during a mismatching read → no error; `enable`=1 later, same read → error. Then 300 mismatching bytes with CNT_W=8 → `err_count`=255 and first-failure fields unchanged after the first.

Source files
------------

// File: rtl/rvfi_check_pkg.sv
// Shared types and width helpers for the RVFI data-memory consistency checkers.
package rvfi_check_pkg;

    localparam int CNT_W_DEF = 8;

    typedef logic [7:0] byte_t;

    // Index fields are sized for the largest supported configuration and cast down at the ports.
    typedef struct packed {
        logic [7:0] chan;
        logic [7:0] slot;
        logic [7:0] byte_lane;
        byte_t      exp;
        byte_t      act;
    } err_info_t;

    function automatic int idx_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/rvfi_dmem_slot.sv
// One tracked word: byte shadow of the last write, forwarded channel by channel in retire order,
// producing per-channel/per-byte mismatch flags and the effective shadow each channel compared against.
module rvfi_dmem_slot
    import rvfi_check_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NRET = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     enable_i,
    input  logic [XLEN-1:0]          slot_addr_i,
    input  logic [NRET-1:0]          valid_i,
    input  logic [NRET*XLEN-1:0]     addr_i,
    input  logic [NRET*XLEN/8-1:0]   rmask_i,
    input  logic [NRET*XLEN/8-1:0]   wmask_i,
    input  logic [NRET*XLEN-1:0]     rdata_i,
    input  logic [NRET*XLEN-1:0]     wdata_i,
    output logic [NRET*XLEN/8-1:0]   mism_o,
    output logic [NRET*XLEN-1:0]     exp_dat_o
);

    localparam int NB = XLEN / 8;
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(NB - 1);

    logic [XLEN-1:0] shadow_q, shadow_d;
    logic [NB-1:0]   written_q, written_d;
    logic [NRET-1:0] hit;
    byte_t           rd_b;

    always_comb begin
        for (int c = 0; c < NRET; c++) begin
            hit[c] = valid_i[c]
                  && (addr_i[c*XLEN +: XLEN] == slot_addr_i)
                  && ((addr_i[c*XLEN +: XLEN] & ALIGN_MASK) == '0);
        end
    end

    // Each channel sees earlier channels' writes; its own write lands after its read check.
    always_comb begin
        shadow_d  = shadow_q;
        written_d = written_q;
        mism_o    = '0;
        exp_dat_o = '0;
        rd_b      = '0;
        for (int c = 0; c < NRET; c++) begin
            exp_dat_o[c*XLEN +: XLEN] = shadow_d;
            for (int i = 0; i < NB; i++) begin
                rd_b = rdata_i[c*XLEN + i*8 +: 8];
                mism_o[c*NB + i] = hit[c] && enable_i && rmask_i[c*NB + i]
                                && written_d[i] && (rd_b != shadow_d[i*8 +: 8]);
            end
            if (hit[c]) begin
                for (int i = 0; i < NB; i++) begin
                    if (wmask_i[c*NB + i]) begin
                        shadow_d[i*8 +: 8] = wdata_i[c*XLEN + i*8 +: 8];
                        written_d[i]       = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadow_q  <= '0;
            written_q <= '0;
        end else begin
            shadow_q  <= shadow_d;
            written_q <= written_d;
        end
    end

endmodule

// File: rtl/rvfi_dmem_multi_check.sv
// Multi-address, multi-channel RVFI data-memory checker: sticky error, saturating mismatch-byte
// counter and first-failure capture, all registered one cycle after the offending retire.
module rvfi_dmem_multi_check
    import rvfi_check_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NRET      = 1,
    parameter int NADDR     = 2,
    parameter int CNT_W     = CNT_W_DEF,
    parameter bit ASSERT_EN = 1'b1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [NADDR*XLEN-1:0]         trk_addr,
    input  logic [NRET-1:0]               rvfi_valid,
    input  logic [NRET*XLEN-1:0]          rvfi_mem_addr,
    input  logic [NRET*XLEN/8-1:0]        rvfi_mem_rmask,
    input  logic [NRET*XLEN/8-1:0]        rvfi_mem_wmask,
    input  logic [NRET*XLEN-1:0]          rvfi_mem_rdata,
    input  logic [NRET*XLEN-1:0]          rvfi_mem_wdata,
    output logic                          err,
    output logic [CNT_W-1:0]              err_count,
    output logic [idx_w(NRET)-1:0]        err_chan,
    output logic [idx_w(NADDR)-1:0]       err_slot,
    output logic [idx_w(XLEN/8)-1:0]      err_byte,
    output logic [7:0]                    err_exp,
    output logic [7:0]                    err_act
);

    localparam int NB     = XLEN / 8;
    localparam int NBIT   = NRET * NB;
    localparam int CHAN_W = idx_w(NRET);
    localparam int SLOT_W = idx_w(NADDR);
    localparam int BYTE_W = idx_w(NB);
    localparam int SUM_W  = CNT_W + $clog2(NADDR * NBIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NBIT-1:0]      mism    [NADDR];
    logic [NRET*XLEN-1:0] exp_dat [NADDR];

    for (genvar k = 0; k < NADDR; k++) begin : g_slot
        rvfi_dmem_slot #(
            .XLEN (XLEN),
            .NRET (NRET)
        ) u_slot (
            .clk_i       (clock),
            .rst_ni      (reset),
            .enable_i    (enable),
            .slot_addr_i (trk_addr[k*XLEN +: XLEN]),
            .valid_i     (rvfi_valid),
            .addr_i      (rvfi_mem_addr),
            .rmask_i     (rvfi_mem_rmask),
            .wmask_i     (rvfi_mem_wmask),
            .rdata_i     (rvfi_mem_rdata),
            .wdata_i     (rvfi_mem_wdata),
            .mism_o      (mism[k]),
            .exp_dat_o   (exp_dat[k])
        );
    end

    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    err_info_t        info_q, info_d, first;
    logic             found;
    logic [SUM_W-1:0] nmis, sum;

    // Loop order (channel, slot, byte) is the first-failure priority.
    always_comb begin
        found = 1'b0;
        first = '0;
        nmis  = '0;
        for (int c = 0; c < NRET; c++) begin
            for (int k = 0; k < NADDR; k++) begin
                for (int i = 0; i < NB; i++) begin
                    if (mism[k][c*NB + i]) begin
                        nmis = nmis + SUM_W'(1);
                        if (!found) begin
                            found           = 1'b1;
                            first.chan      = 8'(c);
                            first.slot      = 8'(k);
                            first.byte_lane = 8'(i);
                            first.exp       = exp_dat[k][c*XLEN + i*8 +: 8];
                            first.act       = rvfi_mem_rdata[c*XLEN + i*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        sum    = SUM_W'(cnt_q) + nmis;
        cnt_d  = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
        err_d  = err_q | found;
        info_d = (!err_q && found) ? first : info_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_q  <= 1'b0;
            cnt_q  <= '0;
            info_q <= '0;
        end else begin
            err_q  <= err_d;
            cnt_q  <= cnt_d;
            info_q <= info_d;
        end
    end

    assign err       = err_q;
    assign err_count = cnt_q;
    assign err_chan  = CHAN_W'(info_q.chan);
    assign err_slot  = SLOT_W'(info_q.slot);
    assign err_byte  = BYTE_W'(info_q.byte_lane);
    assign err_exp   = info_q.exp;
    assign err_act   = info_q.act;

    if (ASSERT_EN) begin : g_assert
        always_comb begin
            if (reset) assert (!found);
        end
    end

endmodule

// File: tb/tb_rvfi_dmem_multi_check.sv
// Randomized and directed bench for rvfi_dmem_multi_check against a byte-array reference model.
module tb_rvfi_dmem_multi_check;

    localparam int XLEN  = 32;
    localparam int NRET  = 2;
    localparam int NADDR = 3;
    localparam int NB    = XLEN / 8;
    localparam int CNT_W = 8;

    logic                  clock = 1'b0;
    logic                  reset = 1'b0;
    logic                  enable = 1'b0;
    logic [NADDR*XLEN-1:0] trk_addr;
    logic [NRET-1:0]       rvfi_valid;
    logic [NRET*XLEN-1:0]  rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
    logic [NRET*NB-1:0]    rvfi_mem_rmask, rvfi_mem_wmask;
    logic                  err;
    logic [CNT_W-1:0]      err_count;
    logic [1:0]            err_chan;
    logic [2:0]            err_slot;
    logic [2:0]            err_byte;
    logic [7:0]            err_exp, err_act;

    rvfi_dmem_multi_check #(
        .XLEN(XLEN), .NRET(NRET), .NADDR(NADDR), .CNT_W(CNT_W), .ASSERT_EN(1'b0)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .trk_addr(trk_addr),
        .rvfi_valid(rvfi_valid), .rvfi_mem_addr(rvfi_mem_addr),
        .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
        .rvfi_mem_rdata(rvfi_mem_rdata), .rvfi_mem_wdata(rvfi_mem_wdata),
        .err(err), .err_count(err_count), .err_chan(err_chan), .err_slot(err_slot),
        .err_byte(err_byte), .err_exp(err_exp), .err_act(err_act)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory contents per tracked slot as byte arrays.
    logic [7:0] m_sh [NADDR][NB];
    bit         m_wr [NADDR][NB];
    bit         m_err;
    int         m_cnt, m_chan, m_slot, m_byte;
    logic [7:0] m_exp, m_act;

    function automatic void model_reset();
        for (int k = 0; k < NADDR; k++)
            for (int i = 0; i < NB; i++) m_wr[k][i] = 1'b0;
        m_err = 1'b0; m_cnt = 0; m_chan = 0; m_slot = 0; m_byte = 0;
        m_exp = 8'h00; m_act = 8'h00;
    endfunction

    function automatic void model_cycle();
        int n;
        bit got;
        logic [31:0] a;
        logic [7:0]  rb;
        if (!reset) begin
            model_reset();
            return;
        end
        n = 0; got = 1'b0;
        for (int c = 0; c < NRET; c++) begin
            a = rvfi_mem_addr[c*XLEN +: XLEN];
            if (!rvfi_valid[c] || (a % NB) != 0) continue;
            for (int k = 0; k < NADDR; k++) begin
                if (a != trk_addr[k*XLEN +: XLEN]) continue;
                for (int i = 0; i < NB; i++) begin
                    rb = rvfi_mem_rdata[c*XLEN + i*8 +: 8];
                    if (enable && rvfi_mem_rmask[c*NB + i] && m_wr[k][i] && rb != m_sh[k][i]) begin
                        n++;
                        if (!got && !m_err) begin
                            got = 1'b1;
                            m_chan = c; m_slot = k; m_byte = i;
                            m_exp = m_sh[k][i]; m_act = rb;
                        end
                    end
                end
                for (int i = 0; i < NB; i++) begin
                    if (rvfi_mem_wmask[c*NB + i]) begin
                        m_sh[k][i] = rvfi_mem_wdata[c*XLEN + i*8 +: 8];
                        m_wr[k][i] = 1'b1;
                    end
                end
            end
        end
        m_cnt = (m_cnt + n > 255) ? 255 : m_cnt + n;
        if (got) m_err = 1'b1;
    endfunction

    // Compare process: mid-cycle, every cycle.
    always @(negedge clock) begin
        chk("err", err, m_err);
        chk("err_count", err_count, m_cnt);
        chk("err_chan", err_chan, m_chan);
        chk("err_slot", err_slot, m_slot);
        chk("err_byte", err_byte, m_byte);
        chk("err_exp", err_exp, m_exp);
        chk("err_act", err_act, m_act);
    end

    task automatic cycle();
        @(posedge clock);
        model_cycle();
        #1;
    endtask

    task automatic idle();
        rvfi_valid = '0; rvfi_mem_addr = '0; rvfi_mem_rmask = '0; rvfi_mem_wmask = '0;
        rvfi_mem_rdata = '0; rvfi_mem_wdata = '0;
    endtask

    task automatic set_ch(input int c, input logic [31:0] a, input logic [3:0] rm,
                          input logic [3:0] wm, input logic [31:0] rd, input logic [31:0] wd);
        rvfi_valid[c] = 1'b1;
        rvfi_mem_addr[c*XLEN +: XLEN]  = a;
        rvfi_mem_rmask[c*NB +: NB]     = rm;
        rvfi_mem_wmask[c*NB +: NB]     = wm;
        rvfi_mem_rdata[c*XLEN +: XLEN] = rd;
        rvfi_mem_wdata[c*XLEN +: XLEN] = wd;
    endtask

    task automatic pulse_reset();
        idle();
        reset = 1'b0;
        model_reset();
        cycle();
        cycle();
        reset = 1'b1;
    endtask

    function automatic logic [31:0] rnd_word();
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[i*8 +: 8] = ($urandom_range(0, 1) != 0) ? 8'h5A : 8'h00;
        return w;
    endfunction

    logic [31:0] addr_tab [4];

    initial begin
        addr_tab[0] = 32'h1000; addr_tab[1] = 32'h1004; addr_tab[2] = 32'h1001; addr_tab[3] = 32'h2000;
        trk_addr = {32'h3000, 32'h2000, 32'h1000};
        idle();
        model_reset();
        cycle();
        cycle();
        chk("reset_err", err, 1'b0);
        chk("reset_count", err_count, 0);
        reset = 1'b1;
        enable = 1'b1;

        // Write then matching read.
        idle(); set_ch(0, 32'h1000, 4'h0, 4'hF, 32'h0, 32'hDEADBEEF); cycle();
        idle(); set_ch(0, 32'h1000, 4'hF, 4'h0, 32'hDEADBEEF, 32'h0); cycle();
        chk("match_err", err, 1'b0);
        chk("match_count", err_count, 0);
        // Byte 0 mismatch.
        idle(); set_ch(0, 32'h1000, 4'hF, 4'h0, 32'hDEADBE00, 32'h0); cycle();
        idle();
        chk("mis_err", err, 1'b1);
        chk("mis_byte", err_byte, 0);
        chk("mis_exp", err_exp, 8'hEF);
        chk("mis_act", err_act, 8'h00);
        chk("mis_count", err_count, 1);

        // Same-cycle forwarding ch0 -> ch1.
        pulse_reset();
        idle(); set_ch(0, 32'h2000, 4'h0, 4'hF, 32'h0, 32'h11223344);
        set_ch(1, 32'h2000, 4'hF, 4'h0, 32'h11223344, 32'h0); cycle();
        chk("fwd_ok_err", err, 1'b0);
        idle(); set_ch(0, 32'h2000, 4'h0, 4'hF, 32'h0, 32'h11223344);
        set_ch(1, 32'h2000, 4'hF, 4'h0, 32'h11223345, 32'h0); cycle();
        idle();
        chk("fwd_err", err, 1'b1);
        chk("fwd_chan", err_chan, 1);
        chk("fwd_slot", err_slot, 1);
        chk("fwd_byte", err_byte, 0);
        chk("fwd_act", err_act, 8'h45);

        // Unwritten read, reset between write and read, misaligned access.
        pulse_reset();
        idle(); set_ch(0, 32'h1000, 4'hF, 4'h0, 32'h12345678, 32'h0); cycle();
        chk("nowrite_err", err, 1'b0);
        idle(); set_ch(0, 32'h1000, 4'h0, 4'hF, 32'h0, 32'hAAAAAAAA); cycle();
        pulse_reset();
        idle(); set_ch(0, 32'h1000, 4'hF, 4'h0, 32'hBBBBBBBB, 32'h0); cycle();
        chk("rst_mid_err", err, 1'b0);
        idle(); set_ch(0, 32'h1001, 4'h0, 4'hF, 32'h0, 32'h12345678); cycle();
        idle(); set_ch(0, 32'h1001, 4'hF, 4'h0, 32'h0, 32'h0); cycle();
        idle(); set_ch(0, 32'h1000, 4'hF, 4'h0, 32'h0, 32'h0); cycle();
        idle();
        chk("misalign_err", err, 1'b0);
        chk("misalign_count", err_count, 0);

        // Enable gating, then saturation with first failure held.
        idle(); set_ch(0, 32'h3000, 4'h0, 4'hF, 32'h0, 32'hCAFEF00D); cycle();
        enable = 1'b0;
        idle(); set_ch(0, 32'h3000, 4'hF, 4'h0, 32'h0, 32'h0); cycle();
        chk("dis_err", err, 1'b0);
        chk("dis_count", err_count, 0);
        enable = 1'b1;
        cycle();
        chk("en_err", err, 1'b1);
        chk("en_count", err_count, 4);
        chk("en_slot", err_slot, 2);
        chk("en_exp", err_exp, 8'h0D);
        idle(); set_ch(0, 32'h3000, 4'hF, 4'h0, 32'hFFFFFFFF, 32'h0);
        for (int n = 0; n < 75; n++) cycle();
        idle();
        chk("sat_count", err_count, 255);
        chk("sat_byte", err_byte, 0);
        chk("sat_exp", err_exp, 8'h0D);
        chk("sat_act", err_act, 8'h00);

        // Duplicate tracked address counts once per slot.
        idle(); reset = 1'b0; model_reset();
        trk_addr = {32'h1000, 32'h1004, 32'h1000};
        cycle(); cycle();
        reset = 1'b1;
        idle(); set_ch(0, 32'h1000, 4'h0, 4'h2, 32'h0, 32'h0000AB00); cycle();
        idle(); set_ch(0, 32'h1000, 4'h2, 4'h0, 32'h0, 32'h0); cycle();
        idle();
        chk("dup_count", err_count, 2);
        chk("dup_slot", err_slot, 0);
        chk("dup_byte", err_byte, 1);
        chk("dup_exp", err_exp, 8'hAB);

        // Randomized traffic with occasional mid-stream resets.
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                pulse_reset();
            end else begin
                enable = ($urandom_range(0, 9) != 0);
                idle();
                for (int c = 0; c < NRET; c++) begin
                    if ($urandom_range(0, 1) != 0)
                        set_ch(c, addr_tab[$urandom_range(0, 3)], 4'($urandom_range(0, 15)),
                               4'($urandom_range(0, 15)), rnd_word(), rnd_word());
                end
                cycle();
            end
        end
        idle();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
